// File: rtl/pkt_buf_pkg.sv
// Shared constants and state encoding for the packet buffer writer.
package pkt_buf_pkg;

  localparam int PKT_ADDR_W = 9;
  localparam int PKT_DATA_W = 64;
  localparam int PKT_CTRL_W = 8;

  localparam logic [PKT_CTRL_W-1:0] CTRL_HDR     = 8'hFF;
  localparam logic [PKT_CTRL_W-1:0] CTRL_PAYLOAD = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DROP    = 2'd2,
    ST_HOLD    = 2'd3
  } state_t;

endpackage

// File: rtl/pkt_buf_addr_ctr.sv
// Buffer write address counter: clear wins over increment; full flags the
// last RAM entry so the writer knows a non-EOP word there overflows.
import pkt_buf_pkg::*;

module pkt_buf_addr_ctr #(
  parameter int ADDR_W = PKT_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] count,
  output logic              full
);

  // counter register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  count <= '0;
    else if (clr)  count <= '0;
    else if (inc)  count <= count + 1'b1;
  end

  assign full = &count;

endmodule

// File: rtl/pkt_buf_writer.sv
// Write-side packet capture engine: stores {ctrl,data} words into the packet
// buffer RAM, publishes tail/last ctrl, and holds the buffer until the CPU
// releases it. Oversize packets are consumed and dropped.
// Optional: define PKT_BUF_WRITER_OVF_CNT_EN to count dropped packets.
import pkt_buf_pkg::*;

module pkt_buf_writer #(
  parameter int ADDR_W = PKT_ADDR_W,
  parameter int DATA_W = PKT_DATA_W,
  parameter int CTRL_W = PKT_CTRL_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [CTRL_W-1:0]        in_ctrl,
  input  logic                     in_wr,
  output logic                     in_rdy,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [CTRL_W+DATA_W-1:0] mem_wdata,
  output logic                     pkt_valid,
  output logic [ADDR_W-1:0]        pkt_tail,
  output logic [CTRL_W-1:0]        pkt_last_ctrl,
  input  logic                     cpu_release,
  output logic [15:0]              ovf_cnt
);

  state_t            state, state_nxt;
  logic              acc;
  logic              ctr_clr, ctr_inc, ctr_full;
  logic [ADDR_W-1:0] ctr;
  logic              wr_nxt, is_last, drop_end;

  assign acc       = in_wr & in_rdy;
  assign pkt_valid = (state == ST_HOLD);

  pkt_buf_addr_ctr #(.ADDR_W(ADDR_W)) u_ctr (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (ctr_clr),
    .inc     (ctr_inc),
    .count   (ctr),
    .full    (ctr_full)
  );

  // next-state, counter control and write strobe decode
  always_comb begin
    state_nxt = state;
    ctr_clr   = 1'b0;
    ctr_inc   = 1'b0;
    wr_nxt    = 1'b0;
    is_last   = 1'b0;
    drop_end  = 1'b0;
    case (state)
      ST_IDLE: begin
        // only a module header starts a packet; stray words are discarded
        if (acc && in_ctrl == CTRL_HDR) begin
          wr_nxt    = 1'b1;
          ctr_inc   = 1'b1;
          state_nxt = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (acc) begin
          wr_nxt  = 1'b1;
          ctr_inc = 1'b1;
          if (in_ctrl != CTRL_PAYLOAD) begin
            // any non-zero ctrl (even a repeated header) closes the packet
            is_last   = 1'b1;
            state_nxt = ST_HOLD;
          end else if (ctr_full) begin
            state_nxt = ST_DROP;
          end
        end
      end
      ST_DROP: begin
        if (acc && in_ctrl != CTRL_PAYLOAD) begin
          drop_end  = 1'b1;
          ctr_clr   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (cpu_release) begin
          ctr_clr   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // state, ready, registered RAM write port and packet descriptor
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      in_rdy        <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      pkt_tail      <= '0;
      pkt_last_ctrl <= '0;
    end else begin
      state  <= state_nxt;
      in_rdy <= (state_nxt != ST_HOLD);
      mem_we <= wr_nxt;
      if (wr_nxt) begin
        mem_addr  <= ctr;
        mem_wdata <= {in_ctrl, in_data};
      end
      if (is_last) begin
        pkt_tail      <= ctr;
        pkt_last_ctrl <= in_ctrl;
      end
    end
  end

`ifdef PKT_BUF_WRITER_OVF_CNT_EN
  logic [15:0] ovf_q;

  // saturating dropped-packet counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                        ovf_q <= '0;
    else if (drop_end && ovf_q != 16'hFFFF) ovf_q <= ovf_q + 16'd1;
  end

  assign ovf_cnt = ovf_q;
`else
  logic drop_end_unused;
  assign drop_end_unused = drop_end;
  assign ovf_cnt         = '0;
`endif

endmodule

// File: tb/tb_pkt_buf_writer.sv
// Scoreboard bench for pkt_buf_writer: expected RAM writes are queued as
// words are driven and checked as mem_we pulses appear.
module tb_pkt_buf_writer;

  localparam int AW = 9;
  localparam int DW = 64;
  localparam int CW = 8;

  typedef struct packed {
    logic [AW-1:0]    addr;
    logic [CW+DW-1:0] wdata;
  } wr_t;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [DW-1:0]     in_data;
  logic [CW-1:0]     in_ctrl;
  logic              in_wr;
  logic              in_rdy;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [CW+DW-1:0]  mem_wdata;
  logic              pkt_valid;
  logic [AW-1:0]     pkt_tail;
  logic [CW-1:0]     pkt_last_ctrl;
  logic              cpu_release;
  logic [15:0]       ovf_cnt;

  int  vec_cnt = 0;
  int  err_cnt = 0;
  int  cyc = 0;
  int  last_acc_cyc = 0;
  int  rel_cyc = 0;
  int  ovf_exp = 0;
  wr_t sb_q[$];

  pkt_buf_writer dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .in_data       (in_data),
    .in_ctrl       (in_ctrl),
    .in_wr         (in_wr),
    .in_rdy        (in_rdy),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .pkt_valid     (pkt_valid),
    .pkt_tail      (pkt_tail),
    .pkt_last_ctrl (pkt_last_ctrl),
    .cpu_release   (cpu_release),
    .ovf_cnt       (ovf_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every registered write must match the oldest queued entry
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("spurious_we", {71'd0, mem_addr}, 80'h1FFFF);
      end else begin
        wr_t e;
        e = sb_q.pop_front();
        chk("wr_addr", {71'd0, mem_addr}, {71'd0, e.addr});
        chk("wr_data", {8'd0, mem_wdata}, {8'd0, e.wdata});
      end
    end
  end

  function automatic logic [DW-1:0] word(input int pkt, input int i);
    return {8'(pkt), 24'h00_0000, 32'(i)};
  endfunction

  // drive one word and wait (bounded) for it to be accepted
  task automatic send(input logic [CW-1:0] c, input logic [DW-1:0] d,
                      input bit exp_wr, input int exp_addr);
    int n;
    wr_t e;
    @(negedge clk);
    in_wr   = 1'b1;
    in_ctrl = c;
    in_data = d;
    if (exp_wr) begin
      e.addr  = AW'(exp_addr);
      e.wdata = {c, d};
      sb_q.push_back(e);
    end
    n = 0;
    while (in_rdy !== 1'b1) begin
      @(negedge clk);
      n++;
      if (n > 50) begin
        chk("rdy_timeout", 80'd0, 80'd1);
        in_wr = 1'b0;
        return;
      end
    end
    last_acc_cyc = cyc;
    @(posedge clk);
  endtask

  task automatic idle_in();
    @(negedge clk);
    in_wr = 1'b0;
  endtask

  task automatic check_hold(input string tag, input int tail, input logic [CW-1:0] lc);
    chk({tag, "_valid"}, {79'd0, pkt_valid}, 80'd1);
    chk({tag, "_tail"}, {71'd0, pkt_tail}, 80'(tail));
    chk({tag, "_lctrl"}, {72'd0, pkt_last_ctrl}, {72'd0, lc});
    chk({tag, "_rdy"}, {79'd0, in_rdy}, 80'd0);
  endtask

  task automatic release_buf(input string tag);
    @(negedge clk);
    cpu_release = 1'b1;
    rel_cyc = cyc;
    @(negedge clk);
    cpu_release = 1'b0;
    chk({tag, "_rel_rdy"}, {79'd0, in_rdy}, 80'd1);
    chk({tag, "_rel_valid"}, {79'd0, pkt_valid}, 80'd0);
  endtask

  task automatic drain(input string tag);
    repeat (3) @(negedge clk);
    #1;
    chk({tag, "_sb_empty"}, 80'(sb_q.size()), 80'd0);
  endtask

  initial begin
    reset_n     = 1'b0;
    in_wr       = 1'b0;
    in_ctrl     = '0;
    in_data     = '0;
    cpu_release = 1'b0;
`ifdef PKT_BUF_WRITER_OVF_CNT_EN
    ovf_exp = 1;
`else
    ovf_exp = 0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_rdy", {79'd0, in_rdy}, 80'd0);
    chk("rst_valid", {79'd0, pkt_valid}, 80'd0);
    chk("rst_we", {79'd0, mem_we}, 80'd0);
    chk("rst_ovf", {64'd0, ovf_cnt}, 80'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_rdy", {79'd0, in_rdy}, 80'd1);

    // basic 5-word packet, back-to-back
    send(8'hFF, word(1, 0), 1, 0);
    for (int i = 1; i <= 3; i++) send(8'h00, word(1, i), 1, i);
    send(8'h0F, word(1, 4), 1, 4);
    idle_in();
    check_hold("p1", 4, 8'h0F);
    release_buf("p1");
    drain("p1");

    // release outside HOLD is ignored; stray payload in IDLE is discarded
    @(negedge clk);
    cpu_release = 1'b1;
    @(negedge clk);
    cpu_release = 1'b0;
    send(8'h00, word(2, 100), 0, 0);
    send(8'h00, word(2, 101), 0, 0);
    send(8'hFF, word(2, 0), 1, 0);
    send(8'h01, word(2, 1), 1, 1);
    idle_in();
    check_hold("p2", 1, 8'h01);
    release_buf("p2");
    drain("p2");

    // oversize packet: 600 words, only 0..511 written, then dropped
    for (int i = 0; i < 600; i++)
      send((i == 0) ? 8'hFF : (i == 599) ? 8'h03 : 8'h00, word(3, i), i <= 511, i);
    idle_in();
    drain("p3");
    chk("p3_valid", {79'd0, pkt_valid}, 80'd0);
    chk("p3_rdy", {79'd0, in_rdy}, 80'd1);
    chk("p3_ovf", {64'd0, ovf_cnt}, 80'(ovf_exp));
    send(8'hFF, word(4, 0), 1, 0);
    send(8'h80, word(4, 1), 1, 1);
    idle_in();
    check_hold("p4", 1, 8'h80);
    release_buf("p4");
    drain("p4");

    // last word exactly at address 511
    for (int i = 0; i < 512; i++)
      send((i == 0) ? 8'hFF : (i == 511) ? 8'h3F : 8'h00, word(5, i), 1, i);
    idle_in();
    check_hold("p5", 511, 8'h3F);
    chk("p5_ovf", {64'd0, ovf_cnt}, 80'(ovf_exp));
    release_buf("p5");
    drain("p5");

    // reset mid-PAYLOAD with counter at 7
    send(8'hFF, word(6, 0), 1, 0);
    for (int i = 1; i <= 6; i++) send(8'h00, word(6, i), 1, i);
    idle_in();
    #2 reset_n = 1'b0;
    #1;
    chk("arst_we", {79'd0, mem_we}, 80'd0);
    chk("arst_addr", {71'd0, mem_addr}, 80'd0);
    chk("arst_wdata", {8'd0, mem_wdata}, 80'd0);
    chk("arst_rdy", {79'd0, in_rdy}, 80'd0);
    chk("arst_tail", {71'd0, pkt_tail}, 80'd0);
    chk("arst_lctrl", {72'd0, pkt_last_ctrl}, 80'd0);
    chk("arst_ovf", {64'd0, ovf_cnt}, 80'd0);
    @(negedge clk);
    reset_n = 1'b1;
    send(8'hFF, word(7, 0), 1, 0);
    send(8'h07, word(7, 1), 1, 1);
    idle_in();
    check_hold("p7", 1, 8'h07);
    release_buf("p7");
    drain("p7");

    // in_wr held high during HOLD; accepted the cycle after release
    send(8'hFF, word(8, 0), 1, 0);
    send(8'h1F, word(8, 1), 1, 1);
    fork
      send(8'hFF, word(9, 0), 1, 0);
      begin
        repeat (3) @(negedge clk);
        chk("p8_hold_rdy", {79'd0, in_rdy}, 80'd0);
        cpu_release = 1'b1;
        rel_cyc = cyc;
        @(negedge clk);
        cpu_release = 1'b0;
      end
    join
    chk("p8_acc_lat", 80'(last_acc_cyc - rel_cyc), 80'd1);
    send(8'h02, word(9, 1), 1, 1);
    idle_in();
    check_hold("p9", 1, 8'h02);
    release_buf("p9");
    drain("p9");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
